// File: rtl/m_mem_arb_pkg.sv
// Shared types and defaults for the fetch/data unified-memory arbiter.
package m_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_I = 2'd1,
        WAIT_D = 2'd2
    } state_e;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_e;

    localparam int unsigned STARVE_MAX_DEFAULT = 32'd4;
    localparam int unsigned TIMEOUT_DEFAULT    = 32'd64;

    // Counter widths cover the full legal parameter ranges (1..15 and 2..255).
    localparam int unsigned STARVE_WIDTH = 32'd4;
    localparam int unsigned WDOG_WIDTH   = 32'd8;

endpackage

// File: rtl/m_arb_sat_counter.sv
// Saturating up-counter with synchronous clear; flags when the count sits at its limit.
module m_arb_sat_counter #(
    parameter int unsigned WIDTH = 32'd4,
    parameter int unsigned LIMIT = 32'd4
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_at_limit
);

    localparam logic [WIDTH-1:0] LIMIT_V = WIDTH'(LIMIT);

    logic [WIDTH-1:0] count_r;

    // Count register: clear beats increment, and the count holds once at the limit.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            count_r <= '0;
        end else if (i_clr) begin
            count_r <= '0;
        end else if (i_inc && (count_r != LIMIT_V)) begin
            count_r <= count_r + WIDTH'(1'b1);
        end
    end

    // Limit flag decoded from the registered count.
    always_comb begin
        o_at_limit = (count_r == LIMIT_V);
    end

endmodule

// File: rtl/m_mem_arbiter.sv
// Non-pipelined arbiter sharing one memory port between instruction fetch and load/store,
// with data priority, a fetch starvation guard and an ack watchdog.
module m_mem_arbiter
    import m_mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT,
    parameter int unsigned TIMEOUT    = TIMEOUT_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    output logic        o_if_gnt,
    output logic        o_if_valid,
    output logic [31:0] o_if_data,
    input  logic        i_d_req,
    input  logic        i_d_we,
    input  logic [31:0] i_d_addr,
    input  logic [31:0] i_d_wdata,
    output logic        o_d_gnt,
    output logic        o_d_valid,
    output logic [31:0] o_d_rdata,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    output logic        o_timeout,
    output logic        o_busy
);

    state_e      state_r;
    state_e      state_next_s;
    owner_e      owner_s;
    logic        if_gnt_s;
    logic        d_gnt_s;
    logic        complete_s;
    logic        timeout_s;
    logic        starve_at_limit_s;
    logic        starve_clr_s;
    logic        starve_inc_s;
    logic        wdog_at_limit_s;
    logic        wdog_clr_s;
    logic        wdog_inc_s;
    logic        mem_req_r;
    logic        mem_we_r;
    logic [31:0] mem_addr_r;
    logic [31:0] mem_wdata_r;
    logic        if_valid_r;
    logic [31:0] if_data_r;
    logic        d_valid_r;
    logic [31:0] d_rdata_r;
    logic        timeout_r;

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (d_gnt_s) begin
                    state_next_s = WAIT_D;
                end else if (if_gnt_s) begin
                    state_next_s = WAIT_I;
                end else begin
                    state_next_s = IDLE;
                end
            end
            WAIT_I, WAIT_D: begin
                if (complete_s || timeout_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = state_r;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Grant decision in IDLE; ack/watchdog completion decode while waiting.
    // Grants are suppressed during reset so nothing is accepted while state is being cleared.
    always_comb begin
        if_gnt_s   = 1'b0;
        d_gnt_s    = 1'b0;
        complete_s = 1'b0;
        timeout_s  = 1'b0;
        owner_s    = OWNER_I;
        case (state_r)
            IDLE: begin
                if (i_reset) begin
                    d_gnt_s  = 1'b0;
                    if_gnt_s = 1'b0;
                end else if (i_d_req && (!i_if_req || !starve_at_limit_s)) begin
                    d_gnt_s = 1'b1;
                end else if (i_if_req) begin
                    if_gnt_s = 1'b1;
                end else begin
                    d_gnt_s  = 1'b0;
                    if_gnt_s = 1'b0;
                end
            end
            WAIT_I, WAIT_D: begin
                owner_s = (state_r == WAIT_D) ? OWNER_D : OWNER_I;
                // A same-cycle ack takes precedence over the watchdog.
                if (i_mem_ack) begin
                    complete_s = 1'b1;
                end else if (wdog_at_limit_s) begin
                    timeout_s = 1'b1;
                end else begin
                    complete_s = 1'b0;
                    timeout_s  = 1'b0;
                end
            end
            default: begin
                owner_s = OWNER_I;
            end
        endcase
    end

    // Counter controls: starvation tracks data wins over a waiting fetch.
    always_comb begin
        starve_inc_s = d_gnt_s & i_if_req;
        starve_clr_s = if_gnt_s | ((state_r == IDLE) & ~i_if_req);
        wdog_clr_s   = d_gnt_s | if_gnt_s;
        wdog_inc_s   = (state_r != IDLE);
    end

    m_arb_sat_counter #(
        .WIDTH (STARVE_WIDTH),
        .LIMIT (STARVE_MAX)
    ) u_starve_cnt (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_clr      (starve_clr_s),
        .i_inc      (starve_inc_s),
        .o_at_limit (starve_at_limit_s)
    );

    // Limit is TIMEOUT-1 because the count is zero during the first waiting cycle.
    m_arb_sat_counter #(
        .WIDTH (WDOG_WIDTH),
        .LIMIT (TIMEOUT - 32'd1)
    ) u_wdog_cnt (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_clr      (wdog_clr_s),
        .i_inc      (wdog_inc_s),
        .o_at_limit (wdog_at_limit_s)
    );

    // Memory-port and response registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 32'h0000_0000;
            mem_wdata_r <= 32'h0000_0000;
            if_valid_r  <= 1'b0;
            if_data_r   <= 32'h0000_0000;
            d_valid_r   <= 1'b0;
            d_rdata_r   <= 32'h0000_0000;
            timeout_r   <= 1'b0;
        end else begin
            if_valid_r <= 1'b0;
            d_valid_r  <= 1'b0;
            timeout_r  <= 1'b0;
            if (d_gnt_s) begin
                mem_req_r   <= 1'b1;
                mem_we_r    <= i_d_we;
                mem_addr_r  <= i_d_addr;
                mem_wdata_r <= i_d_wdata;
            end else if (if_gnt_s) begin
                mem_req_r   <= 1'b1;
                mem_we_r    <= 1'b0;
                mem_addr_r  <= i_if_addr;
                mem_wdata_r <= 32'h0000_0000;
            end else if (complete_s || timeout_s) begin
                mem_req_r <= 1'b0;
            end
            if (complete_s) begin
                if (owner_s == OWNER_D) begin
                    d_valid_r <= 1'b1;
                    d_rdata_r <= mem_we_r ? 32'h0000_0000 : i_mem_rdata;
                end else begin
                    if_valid_r <= 1'b1;
                    if_data_r  <= i_mem_rdata;
                end
            end else if (timeout_s) begin
                timeout_r <= 1'b1;
                if (owner_s == OWNER_D) begin
                    d_valid_r <= 1'b1;
                    d_rdata_r <= 32'h0000_0000;
                end else begin
                    if_valid_r <= 1'b1;
                    if_data_r  <= 32'h0000_0000;
                end
            end
        end
    end

    assign o_if_gnt    = if_gnt_s;
    assign o_d_gnt     = d_gnt_s;
    assign o_if_valid  = if_valid_r;
    assign o_if_data   = if_data_r;
    assign o_d_valid   = d_valid_r;
    assign o_d_rdata   = d_rdata_r;
    assign o_mem_req   = mem_req_r;
    assign o_mem_we    = mem_we_r;
    assign o_mem_addr  = mem_addr_r;
    assign o_mem_wdata = mem_wdata_r;
    assign o_timeout   = timeout_r;
    assign o_busy      = (state_r != IDLE);

endmodule

// File: tb/tb_m_mem_arbiter.sv
// Directed bench for m_mem_arbiter with a bench-side memory model and a completion scoreboard.
module tb_m_mem_arbiter;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_if_req;
    logic [31:0] i_if_addr;
    logic        o_if_gnt;
    logic        o_if_valid;
    logic [31:0] o_if_data;
    logic        i_d_req;
    logic        i_d_we;
    logic [31:0] i_d_addr;
    logic [31:0] i_d_wdata;
    logic        o_d_gnt;
    logic        o_d_valid;
    logic [31:0] o_d_rdata;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;
    logic        o_timeout;
    logic        o_busy;

    typedef struct {
        bit          is_d;
        logic [31:0] data;
        bit          to;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          ack_after = 0;
    int          req_cycles = 0;
    bit          hold_d = 1'b0;
    bit          hold_if = 1'b0;
    bit          last_d_gnt = 1'b0;
    bit          last_if_gnt = 1'b0;
    bit          prev_req = 1'b0;
    int          grant_cnt = 0;
    logic [31:0] grant_bits = 32'd0;
    int          req_rise_cyc = 0;
    int          valid_cyc = 0;

    always #5 i_clk = ~i_clk;

    m_mem_arbiter #(
        .STARVE_MAX (4),
        .TIMEOUT    (8)
    ) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_if_req    (i_if_req),
        .i_if_addr   (i_if_addr),
        .o_if_gnt    (o_if_gnt),
        .o_if_valid  (o_if_valid),
        .o_if_data   (o_if_data),
        .i_d_req     (i_d_req),
        .i_d_we      (i_d_we),
        .i_d_addr    (i_d_addr),
        .i_d_wdata   (i_d_wdata),
        .o_d_gnt     (o_d_gnt),
        .o_d_valid   (o_d_valid),
        .o_d_rdata   (o_d_rdata),
        .o_mem_req   (o_mem_req),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_ack   (i_mem_ack),
        .i_mem_rdata (i_mem_rdata),
        .o_timeout   (o_timeout),
        .o_busy      (o_busy)
    );

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a == 32'h0000_0100) ? 32'hDEAD_BEEF : (a ^ 32'hC0DE_0000);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input bit is_d, input logic [31:0] data, input bit to);
        exp_t e;
        e.is_d = is_d;
        e.data = data;
        e.to   = to;
        sb.push_back(e);
    endtask

    // Advance to just after the next rising edge; retire granted requests and play the memory.
    task automatic step();
        @(posedge i_clk);
        #1;
        cyc++;
        if (last_d_gnt && !hold_d) i_d_req = 1'b0;
        if (last_if_gnt && !hold_if) i_if_req = 1'b0;
        last_d_gnt  = 1'b0;
        last_if_gnt = 1'b0;
        if (o_mem_req) req_cycles++;
        else req_cycles = 0;
        if (o_mem_req && (ack_after != 0) && (req_cycles == ack_after)) begin
            i_mem_ack   = 1'b1;
            i_mem_rdata = mem_fn(o_mem_addr);
        end else begin
            i_mem_ack   = 1'b0;
            i_mem_rdata = 32'hBAD0_0000 | 32'(cyc);
        end
    endtask

    // Sample at the falling edge: log grants, track timing, score any completion.
    task automatic mid();
        exp_t e;
        @(negedge i_clk);
        last_d_gnt  = o_d_gnt;
        last_if_gnt = o_if_gnt;
        if (o_d_gnt || o_if_gnt) begin
            if (o_if_gnt) grant_bits = grant_bits | (32'd1 << grant_cnt);
            grant_cnt++;
        end
        if (o_mem_req && !prev_req) req_rise_cyc = cyc;
        prev_req = o_mem_req;
        if (o_d_valid || o_if_valid) begin
            valid_cyc = cyc;
            if (sb.size() == 0) begin
                chk("unexpected_valid", 32'({o_d_valid, o_if_valid}), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_owner", 32'({o_d_valid, o_if_valid}), e.is_d ? 32'd2 : 32'd1);
                chk("sb_data", o_d_valid ? o_d_rdata : o_if_data, e.data);
                chk("sb_timeout", 32'(o_timeout), 32'(e.to));
            end
        end else begin
            chk("stray_timeout", 32'(o_timeout), 32'd0);
        end
    endtask

    task automatic wait_done(input int max, input string tag);
        for (int i = 0; i < max; i++) begin
            if (sb.size() == 0) break;
            step();
            mid();
        end
        chk(tag, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        i_reset = 1'b1; i_if_req = 1'b0; i_if_addr = 32'd0; i_d_req = 1'b0; i_d_we = 1'b0;
        i_d_addr = 32'd0; i_d_wdata = 32'd0; i_mem_ack = 1'b0; i_mem_rdata = 32'd0;

        // Reset state
        step(); step(); mid();
        chk("reset_ctrl", 32'({o_busy, o_mem_req, o_mem_we, o_if_gnt, o_d_gnt, o_if_valid, o_d_valid, o_timeout}), 32'd0);
        chk("reset_addr", o_mem_addr, 32'd0);
        chk("reset_wdata", o_mem_wdata, 32'd0);
        chk("reset_rdata", o_d_rdata | o_if_data, 32'd0);
        step(); i_reset = 1'b0; mid();

        // Single load: grant, request next cycle, valid two cycles after grant
        step(); i_d_req = 1'b1; i_d_we = 1'b0; i_d_addr = 32'h0000_0100; ack_after = 1;
        push_exp(1'b1, 32'hDEAD_BEEF, 1'b0);
        mid();
        chk("load_gnt", 32'({o_d_gnt, o_if_gnt}), 32'd2);
        step(); mid();
        chk("load_req", 32'({o_mem_req, o_mem_we, o_busy}), 32'd5);
        chk("load_addr", o_mem_addr, 32'h0000_0100);
        step(); mid();
        chk("load_valid", 32'({o_d_valid, o_if_valid, o_mem_req}), 32'd4);

        // Store held for three cycles, then zero read data
        step(); i_d_req = 1'b1; i_d_we = 1'b1; i_d_addr = 32'h0000_0040; i_d_wdata = 32'h1234_5678;
        ack_after = 3; push_exp(1'b1, 32'd0, 1'b0);
        mid();
        chk("store_gnt", 32'(o_d_gnt), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(); mid();
            chk("store_hold_ctl", 32'({o_mem_req, o_mem_we, o_d_valid}), 32'd6);
            chk("store_hold_wdata", o_mem_wdata, 32'h1234_5678);
        end
        step(); mid();
        chk("store_valid", 32'(o_d_valid), 32'd1);

        // Both requesting with instant ack: D,D,D,D,I,D
        step(); i_d_we = 1'b0; i_d_addr = 32'h0000_0200; i_if_addr = 32'h0000_0300;
        i_d_req = 1'b1; i_if_req = 1'b1; hold_d = 1'b1; ack_after = 1;
        grant_cnt = 0; grant_bits = 32'd0;
        for (int i = 0; i < 4; i++) push_exp(1'b1, mem_fn(32'h0000_0200), 1'b0);
        push_exp(1'b0, mem_fn(32'h0000_0300), 1'b0);
        push_exp(1'b1, mem_fn(32'h0000_0200), 1'b0);
        mid();
        for (int i = 0; i < 40; i++) begin
            if (grant_cnt >= 6) break;
            step(); mid();
        end
        hold_d = 1'b0;
        chk("starve_grants", 32'(grant_cnt), 32'd6);
        chk("starve_order", grant_bits, 32'h0000_0010);
        wait_done(20, "starve_drain");

        // Watchdog: no ack, abort 8 cycles after the request rises
        step(); i_d_req = 1'b1; i_d_addr = 32'h0000_0500; ack_after = 0;
        push_exp(1'b1, 32'd0, 1'b1);
        mid();
        chk("to_gnt", 32'(o_d_gnt), 32'd1);
        wait_done(30, "to_done");
        chk("to_latency", 32'(valid_cyc - req_rise_cyc), 32'd8);
        step(); i_mem_ack = 1'b1; i_mem_rdata = 32'hFEED_FACE; mid();
        step(); mid();
        chk("stray_ack", 32'({o_d_valid, o_if_valid, o_busy, o_mem_req}), 32'd0);

        // Ack on the watchdog's last cycle completes normally
        step(); i_if_req = 1'b1; i_if_addr = 32'h0000_0600; ack_after = 8;
        push_exp(1'b0, mem_fn(32'h0000_0600), 1'b0);
        mid();
        chk("tie_gnt", 32'({o_if_gnt, o_d_gnt}), 32'd2);
        wait_done(30, "tie_done");
        chk("tie_latency", 32'(valid_cyc - req_rise_cyc), 32'd8);

        // Reset while data owns the port, then an immediate fetch
        step(); i_d_req = 1'b1; i_d_addr = 32'h0000_0700; ack_after = 0; mid();
        chk("rst_gnt", 32'(o_d_gnt), 32'd1);
        step(); mid();
        step(); mid();
        chk("rst_in_wait", 32'({o_busy, o_mem_req}), 32'd3);
        step(); i_reset = 1'b1; mid();
        step(); i_reset = 1'b0; i_if_req = 1'b1; i_if_addr = 32'h0000_0800; ack_after = 1;
        push_exp(1'b0, mem_fn(32'h0000_0800), 1'b0);
        mid();
        chk("rst_state", 32'({o_mem_req, o_busy, o_d_valid}), 32'd0);
        chk("rst_fetch_gnt", 32'(o_if_gnt), 32'd1);
        wait_done(20, "rst_fetch_done");

        for (int i = 0; i < 3; i++) begin
            step(); mid();
            chk("final_quiet", 32'({o_busy, o_mem_req, o_d_valid, o_if_valid}), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
